// File: rtl/exp_result_drain_if.sv
// FIFO read port between the exponential accumulator's output FIFO and its consumer.
// Handshake: `ready` means the FIFO is non-empty; a one-cycle `read` pops a word, and `q` carries it the cycle after.
interface exp_result_drain_if #(
    parameter int DATA_W = 18
);
    logic              ready;
    logic [DATA_W-1:0] q;
    logic              read;

    modport master (
        input  ready,
        input  q,
        output read
    );

    modport slave (
        output ready,
        output q,
        input  read
    );
endinterface

// File: rtl/exp_result_drain.sv
// Drains NUM_WORDS results from the accumulator FIFO per `go`, summing them and tracking the maximum.
// Each word costs WAIT -> POP -> CAPTURE, so `ready` is always re-sampled after the FIFO has updated.
module exp_result_drain #(
    parameter int DATA_W    = 18,
    parameter int NUM_WORDS = 5,
    parameter int SUM_W     = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    exp_result_drain_if.master    fifo,
    output logic                  busy,
    output logic                  done,
    output logic [SUM_W-1:0]      sum,
    output logic [DATA_W-1:0]     max_val,
    output logic [3:0]            count,
    output logic                  ovf,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_POP     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] LP_NUM_WORDS = 4'(NUM_WORDS);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_max;
    logic [3:0]        r_count;
    logic              r_ovf;

    logic [SUM_W:0]    w_sum_ext;
    logic [3:0]        w_count_inc;
    logic              w_last_word;
    logic              w_new_max;

    // One extra bit on the adder so the carry-out can feed the sticky overflow flag.
    assign w_sum_ext   = {1'b0, r_sum} + (SUM_W+1)'(fifo.q);
    assign w_count_inc = r_count + 4'd1;
    assign w_last_word = (w_count_inc == LP_NUM_WORDS);
    assign w_new_max   = (fifo.q > r_max);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fifo.ready) begin
                    w_state_next = S_POP;
                end
            end
            S_POP: begin
                w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_next = w_last_word ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sum   <= '0;
            r_max   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    // Results from the previous session hold until the next start.
                    if (go) begin
                        r_sum   <= '0;
                        r_max   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    r_sum   <= w_sum_ext[SUM_W-1:0];
                    r_ovf   <= r_ovf | w_sum_ext[SUM_W];
                    r_count <= w_count_inc;
                    if (w_new_max) begin
                        r_max <= fifo.q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fifo.read = (r_state == S_POP);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign max_val   = r_max;
    assign count     = r_count;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: doc/exp_result_drain.md
Name: exp_result_drain

Overview:
- Downstream consumer of the exponential accumulator.
- On a `go` pulse it drains NUM_WORDS results from the accumulator's output FIFO using that block's ready/read handshake.
- It accumulates their sum and tracks the largest value, then reports completion with a one-cycle `done`.
- Its outputs feed the board display/checker logic.

Parameters:
- DATA_W, 18, width of each result word `q`.
- NUM_WORDS, 5, number of words popped per session (1..8, matches FIFO depth 8).
- SUM_W, 21, width of the sum register (DATA_W + 3).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  starts a drain session; sampled only in IDLE.
- ready  input  1  from accumulator: FIFO non-empty.
- q  input  DATA_W  FIFO read data; valid the cycle after `read` is high (normal-mode FIFO).
- read  output  1  one-cycle pop strobe to the FIFO.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at session end.
- sum  output  SUM_W  running/final sum of popped words.
- max_val  output  DATA_W  largest word popped this session.
- count  output  4  words popped this session.
- ovf  output  1  sticky carry-out of `sum` for this session.

Behaviour:
- Reset (`rst`=1 at an edge): FSM goes to IDLE; `read`, `busy`, `done`, `sum`, `max_val`, `count`, `ovf` all become 0. Reset mid-session aborts immediately; no further `read` is issued.
- All outputs are registered or Moore-decoded from state. `read`=1 only in POP; `done`=1 only in DONE.
- IDLE: if `go`=1, clear `sum`, `max_val`, `count`, `ovf` and go to WAIT. Otherwise stay in IDLE and hold all results from the previous session.
- WAIT: if `ready`=1, go to POP; else stay (waits indefinitely; no timeout).
- POP: `read`=1 for exactly this cycle; next state is CAPTURE unconditionally.
- CAPTURE: capture `q` on this edge.
  - `sum <= sum + q`, zero-extended to SUM_W+1 bits. Bit SUM_W ORs into `ovf`; `sum` keeps the low SUM_W bits (wraps).
  - `max_val <= q` if `q` > `max_val` (unsigned).
  - `count <= count + 1`.
  - If the new count equals NUM_WORDS, go to DONE; else go to WAIT.
- DONE: `done`=1 for one cycle, then IDLE.
- Minimum per-word cost is 3 cycles (WAIT, POP, CAPTURE). WAIT re-samples `ready` after the FIFO has updated, so no pop is ever issued on an empty FIFO.
- `go` while `busy`=1, including in DONE, is ignored; `go` held high is not a retrigger until IDLE is re-entered.
- `ready` dropping during POP or CAPTURE is irrelevant; the pop was already committed.
- Latency, `go` to `done`, with `ready` constantly high: 1 + 3·NUM_WORDS cycles (16 for the default), with `done` high in the cycle after the last CAPTURE.

Test Plan:
- Reset: drive `rst`=1 for 1 edge mid-session (after the 2nd pop) -> next cycle all outputs 0, state IDLE, `read` stays 0 while `ready`=1.
- Nominal: FIFO preloaded with 1, 2, 3, 4, 5 and `ready` high, pulse `go` -> exactly 5 single-cycle `read` pulses 3 cycles apart. `done` pulses 16 cycles after `go`. Final `sum`=15, `max_val`=5, `count`=5, `ovf`=0.
- Stalled producer: `ready` low for 20 cycles between words 2 and 3 -> `read` stays low and the FSM holds in WAIT. The session completes with the correct `sum`; no extra pops.
- Max/unsigned: words 0x3FFFF, 0x00001, 0x20000, 0x10000, 0x00000 -> `max_val`=0x3FFFF, `sum`=0x70000 (458752), `ovf`=0.
- Overflow with SUM_W=20: five words of 0x3FFFF -> `ovf`=1, `sum`=262139 (1310715 mod 2^20).
- Ignored `go`: pulse `go` during session and during the DONE cycle -> no restart. Results hold in IDLE until the next `go`, which clears them to 0 one cycle later.
